// File: rtl/bfs_dc_arbiter_if.sv
// Cache-side read port of the BFS data-cache arbiter.
// master: the arbiter (drives request/address, consumes ready/response).
// slave:  the bfs_cache read port.
interface bfs_dc_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              bfs_dc_req;
    logic [ADDR_W-1:0] bfs_dc_addr;
    logic              dc_ready;
    logic              dc_fs;
    logic [63:0]       dc_rdata;
    logic              dc_rbuf_empty;

    modport master (
        output bfs_dc_req,
        output bfs_dc_addr,
        input  dc_ready,
        input  dc_fs,
        input  dc_rdata,
        input  dc_rbuf_empty
    );

    modport slave (
        input  bfs_dc_req,
        input  bfs_dc_addr,
        output dc_ready,
        output dc_fs,
        output dc_rdata,
        output dc_rbuf_empty
    );
endinterface

// File: rtl/bfs_dc_arbiter.sv
// bfs_dc_arbiter: shares the single bfs_cache read port between bfs_core
// (requester 0) and the BFS edge prefetch lane (requester 1).
// Round-robin on the request side; an in-order owner FIFO steers each
// returning response back to its issuer; rob_flush squashes requester-0
// responses still in flight.
// Optional feature: define BFS_DCARB_STATS_EN to add 32-bit grant/squash
// counters (stat_grant0, stat_grant1, stat_squash).
module bfs_dc_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_grant,
    output logic              r0_valid,
    output logic [63:0]       r0_rdata,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r1_grant,
    output logic              r1_valid,
    output logic [63:0]       r1_rdata,
    bfs_dc_arbiter_if.master  dc,
    input  logic              rob_flush,
    output logic              arb_idle,
    output logic              arb_err
`ifdef BFS_DCARB_STATS_EN
    ,
    output logic [31:0]       stat_grant0,
    output logic [31:0]       stat_grant1,
    output logic [31:0]       stat_squash
`endif
);

    localparam int CW = $clog2(OUTSTANDING);

    typedef logic [CW:0]   cnt_t;
    typedef logic [CW-1:0] ptr_t;

    localparam cnt_t FULL_CNT = cnt_t'(OUTSTANDING);

    // Owner FIFO state: count/pointers are control, owner/squash are payload.
    cnt_t                   count_q, count_d;
    ptr_t                   wr_ptr_q, wr_ptr_d;
    ptr_t                   rd_ptr_q, rd_ptr_d;
    logic [OUTSTANDING-1:0] owner_q, owner_d;
    logic [OUTSTANDING-1:0] squash_q, squash_d;
    logic                   last_q, last_d;
    logic                   err_q, err_d;

    logic              elig0, elig1, any_req, sel, fifo_full;
    logic              dc_req, accept, pop;
    logic              head_owner, head_squash, squash_pop;
    logic [ADDR_W-1:0] dc_addr;

    // Request arbitration, cache request/address, response steering.
    always_comb begin
        elig0   = r0_req & ~rob_flush;
        elig1   = r1_req;
        any_req = elig0 | elig1;
        // On a tie the requester that did not win last time goes; otherwise
        // whoever is asking wins.
        sel       = (elig0 & elig1) ? ~last_q : elig1;
        // Full is taken from the registered count only: a pop this cycle does
        // not open a slot until the next cycle.
        fifo_full = (count_q == FULL_CNT);
        dc_req    = any_req & ~fifo_full;
        dc_addr   = '0;
        if (any_req) begin
            dc_addr = sel ? r1_addr : r0_addr;
        end
        accept   = dc_req & dc.dc_ready;
        r0_grant = accept & ~sel;
        r1_grant = accept & sel;

        pop         = dc.dc_fs & (count_q != '0);
        head_owner  = owner_q[rd_ptr_q];
        // A flush in the same cycle as the response also kills a requester-0 head.
        head_squash = ~head_owner & (squash_q[rd_ptr_q] | rob_flush);
        r0_valid    = pop & ~head_owner & ~head_squash;
        r1_valid    = pop & head_owner;
        squash_pop  = pop & head_squash;
        r0_rdata    = r0_valid ? dc.dc_rdata : 64'd0;
        r1_rdata    = r1_valid ? dc.dc_rdata : 64'd0;
    end

    assign dc.bfs_dc_req  = dc_req;
    assign dc.bfs_dc_addr = dc_addr;
    assign arb_idle       = (count_q == '0) & dc.dc_rbuf_empty;
    assign arb_err        = err_q;

    // Next-state for the owner FIFO, round-robin pointer and error flag.
    always_comb begin
        owner_d  = owner_q;
        squash_d = squash_q;
        if (rob_flush) begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (!owner_q[i]) begin
                    squash_d[i] = 1'b1;
                end
            end
        end
        wr_ptr_d = wr_ptr_q;
        if (accept) begin
            owner_d[wr_ptr_q]  = sel;
            squash_d[wr_ptr_q] = rob_flush & ~sel;
            wr_ptr_d           = wr_ptr_q + ptr_t'(1);
        end
        rd_ptr_d = pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        count_d  = count_q + cnt_t'(accept) - cnt_t'(pop);
        last_d   = accept ? sel : last_q;
        // Any response with nothing outstanding is a protocol error; the data is dropped.
        err_d    = err_q | (dc.dc_fs & (count_q == '0));
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    // FIFO payload; only meaningful below count_q, so it needs no reset.
    always_ff @(posedge clk) begin
        owner_q  <= owner_d;
        squash_q <= squash_d;
    end

`ifdef BFS_DCARB_STATS_EN
    logic [31:0] stat_grant0_q, stat_grant0_d;
    logic [31:0] stat_grant1_q, stat_grant1_d;
    logic [31:0] stat_squash_q, stat_squash_d;

    // Free-running event counters, wrapping at 2^32.
    always_comb begin
        stat_grant0_d = stat_grant0_q + {31'd0, r0_grant};
        stat_grant1_d = stat_grant1_q + {31'd0, r1_grant};
        stat_squash_d = stat_squash_q + {31'd0, squash_pop};
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant0_q <= '0;
            stat_grant1_q <= '0;
            stat_squash_q <= '0;
        end else begin
            stat_grant0_q <= stat_grant0_d;
            stat_grant1_q <= stat_grant1_d;
            stat_squash_q <= stat_squash_d;
        end
    end

    assign stat_grant0 = stat_grant0_q;
    assign stat_grant1 = stat_grant1_q;
    assign stat_squash = stat_squash_q;
`endif

endmodule

// File: tb/tb_bfs_dc_arbiter.sv
// Testbench for bfs_dc_arbiter: directed scenarios with a response scoreboard.
module tb_bfs_dc_arbiter;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              r0_req, r1_req, rob_flush;
    logic [ADDR_W-1:0] r0_addr, r1_addr;
    logic              r0_grant, r0_valid, r1_grant, r1_valid;
    logic [63:0]       r0_rdata, r1_rdata;
    logic              arb_idle, arb_err;
`ifdef BFS_DCARB_STATS_EN
    logic [31:0]       stat_grant0, stat_grant1, stat_squash;
`endif

    typedef struct packed {
        logic        owner;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bfs_dc_arbiter_if #(.ADDR_W(ADDR_W)) dc_if ();

    bfs_dc_arbiter #(.OUTSTANDING(4), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .r0_req    (r0_req),
        .r0_addr   (r0_addr),
        .r0_grant  (r0_grant),
        .r0_valid  (r0_valid),
        .r0_rdata  (r0_rdata),
        .r1_req    (r1_req),
        .r1_addr   (r1_addr),
        .r1_grant  (r1_grant),
        .r1_valid  (r1_valid),
        .r1_rdata  (r1_rdata),
        .dc        (dc_if),
        .rob_flush (rob_flush),
        .arb_idle  (arb_idle),
        .arb_err   (arb_err)
`ifdef BFS_DCARB_STATS_EN
        ,
        .stat_grant0 (stat_grant0),
        .stat_grant1 (stat_grant1),
        .stat_squash (stat_squash)
`endif
    );

    always #5 clk = ~clk;

    // Response monitor: every delivered response must match the scoreboard head.
    always @(negedge clk) begin : resp_mon
        exp_t        e;
        logic [63:0] got;
        if (rst === 1'b0 && (r0_valid === 1'b1 || r1_valid === 1'b1)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected r0_valid=%0b r1_valid=%0b required no response", r0_valid, r1_valid);
            end else begin
                e = exp_q.pop_front();
                if ({r1_valid, r0_valid} !== (e.owner ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL resp_owner got r1/r0 valid=%b%b required owner %0d", r1_valid, r0_valid, e.owner);
                end
                checks++;
                got = e.owner ? r1_rdata : r0_rdata;
                if (got !== e.data) begin
                    errors++;
                    $display("FAIL resp_data got %h required %h", got, e.data);
                end
                checks++;
                got = e.owner ? r0_rdata : r1_rdata;
                if (got !== 64'd0) begin
                    errors++;
                    $display("FAIL resp_other_rdata got %h required 0", got);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; r0_req = 0; r1_req = 0; r0_addr = '0; r1_addr = '0; rob_flush = 0;
        dc_if.dc_ready = 0; dc_if.dc_fs = 0; dc_if.dc_rdata = '0; dc_if.dc_rbuf_empty = 1;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (dc_if.bfs_dc_req !== 1'b0) begin errors++; $display("FAIL reset_dc_req got %b required 0", dc_if.bfs_dc_req); end
        checks++; if ({r0_grant, r1_grant, r0_valid, r1_valid} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b required 0000", {r0_grant, r1_grant, r0_valid, r1_valid}); end
        checks++; if (r0_rdata !== 64'd0 || r1_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h/%h required 0", r0_rdata, r1_rdata); end
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b required 0", arb_err); end
        checks++; if (arb_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b required 1", arb_idle); end
        dc_if.dc_rbuf_empty = 0; #1;
        checks++; if (arb_idle !== 1'b0) begin errors++; $display("FAIL reset_idle_rbuf got %b required 0", arb_idle); end
        dc_if.dc_rbuf_empty = 1;
`ifdef BFS_DCARB_STATS_EN
        checks++; if (stat_grant0 !== 0 || stat_grant1 !== 0 || stat_squash !== 0) begin errors++; $display("FAIL reset_stats got %0d/%0d/%0d required 0", stat_grant0, stat_grant1, stat_squash); end
`endif
    endtask

    task automatic test_single();
        r0_req = 1; r0_addr = 32'h00C0; dc_if.dc_ready = 1; #1;
        checks++; if (dc_if.bfs_dc_req !== 1'b1 || dc_if.bfs_dc_addr !== 32'h00C0) begin errors++; $display("FAIL single_req got %b/%h required 1/000000c0", dc_if.bfs_dc_req, dc_if.bfs_dc_addr); end
        checks++; if (r0_grant !== 1'b1 || r1_grant !== 1'b0) begin errors++; $display("FAIL single_grant got %b%b required 10", r0_grant, r1_grant); end
        tick();
        r0_req = 0; dc_if.dc_ready = 0; #1;
        checks++; if (r0_grant !== 1'b0 || dc_if.bfs_dc_addr !== '0) begin errors++; $display("FAIL single_idle got %b/%h required 0/0", r0_grant, dc_if.bfs_dc_addr); end
        dc_if.dc_fs = 1; dc_if.dc_rdata = 64'hDEAD_BEEF; exp_q.push_back('{1'b0, 64'hDEAD_BEEF}); #1;
        checks++; if (r0_valid !== 1'b1 || r0_rdata !== 64'hDEAD_BEEF || r1_valid !== 1'b0) begin errors++; $display("FAIL single_resp got %b/%h/%b required 1/deadbeef/0", r0_valid, r0_rdata, r1_valid); end
        tick();
        dc_if.dc_fs = 0;
    endtask

    task automatic test_backpressure();
        r1_req = 1; r1_addr = 32'h0180; dc_if.dc_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (r1_grant !== 1'b0 || dc_if.bfs_dc_addr !== 32'h0180 || dc_if.bfs_dc_req !== 1'b1) begin errors++; $display("FAIL bp_hold cyc %0d got grant=%b addr=%h req=%b required 0/00000180/1", i, r1_grant, dc_if.bfs_dc_addr, dc_if.bfs_dc_req); end
            tick();
        end
        dc_if.dc_ready = 1; #1;
        checks++; if (r1_grant !== 1'b1 || r0_grant !== 1'b0) begin errors++; $display("FAIL bp_grant got r1=%b r0=%b required 1/0", r1_grant, r0_grant); end
        tick();
        r1_req = 0; dc_if.dc_ready = 0;
        dc_if.dc_fs = 1; dc_if.dc_rdata = 64'h180; exp_q.push_back('{1'b1, 64'h180});
        tick();
        dc_if.dc_fs = 0;
    endtask

    task automatic test_tie();
        logic exp_r0;
        r0_req = 1; r1_req = 1; r0_addr = 32'h0100; r1_addr = 32'h0200; dc_if.dc_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_r0 = (i % 2 == 0);
            checks++; if (r0_grant !== exp_r0 || r1_grant !== ~exp_r0) begin errors++; $display("FAIL tie_grant cyc %0d got r0=%b r1=%b required r0=%b", i, r0_grant, r1_grant, exp_r0); end
            checks++; if (dc_if.bfs_dc_addr !== (exp_r0 ? 32'h0100 : 32'h0200)) begin errors++; $display("FAIL tie_addr cyc %0d got %h", i, dc_if.bfs_dc_addr); end
            tick();
        end
        r0_req = 0; r1_req = 0; dc_if.dc_ready = 0;
        for (int i = 0; i < 4; i++) begin
            dc_if.dc_fs = 1; dc_if.dc_rdata = 64'(i + 1);
            exp_q.push_back('{logic'(i % 2), 64'(i + 1)});
            tick();
        end
        dc_if.dc_fs = 0;
    endtask

    task automatic test_full();
        r0_req = 1; r1_req = 0; r0_addr = 32'h0300; dc_if.dc_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (r0_grant !== 1'b1) begin errors++; $display("FAIL full_fill cyc %0d got %b required 1", i, r0_grant); end
            tick();
        end
        #1;
        checks++; if (dc_if.bfs_dc_req !== 1'b0 || r0_grant !== 1'b0) begin errors++; $display("FAIL full_block got req=%b grant=%b required 0/0", dc_if.bfs_dc_req, r0_grant); end
        tick();
        dc_if.dc_fs = 1; dc_if.dc_rdata = 64'hF0; exp_q.push_back('{1'b0, 64'hF0}); #1;
        checks++; if (dc_if.bfs_dc_req !== 1'b0) begin errors++; $display("FAIL full_no_bypass got %b required 0", dc_if.bfs_dc_req); end
        tick();
        dc_if.dc_fs = 0; #1;
        checks++; if (dc_if.bfs_dc_req !== 1'b1 || r0_grant !== 1'b1) begin errors++; $display("FAIL full_reissue got req=%b grant=%b required 1/1", dc_if.bfs_dc_req, r0_grant); end
        tick();
        r0_req = 0; dc_if.dc_ready = 0;
        for (int i = 0; i < 4; i++) begin
            dc_if.dc_fs = 1; dc_if.dc_rdata = 64'hF1 + 64'(i);
            exp_q.push_back('{1'b0, 64'hF1 + 64'(i)});
            tick();
        end
        dc_if.dc_fs = 0; #1;
        checks++; if (arb_idle !== 1'b1) begin errors++; $display("FAIL full_drained_idle got %b required 1", arb_idle); end
    endtask

    task automatic test_flush();
        int pulses = 0;
        dc_if.dc_ready = 1;
        r0_req = 1; r0_addr = 32'h0400; #1;
        checks++; if (r0_grant !== 1'b1) begin errors++; $display("FAIL flush_issue0 got %b required 1", r0_grant); end
        tick();
        r0_req = 0; r1_req = 1; r1_addr = 32'h0500; #1;
        checks++; if (r1_grant !== 1'b1) begin errors++; $display("FAIL flush_issue1 got %b required 1", r1_grant); end
        tick();
        r1_req = 0; r0_req = 1; r0_addr = 32'h0600; #1;
        checks++; if (r0_grant !== 1'b1) begin errors++; $display("FAIL flush_issue2 got %b required 1", r0_grant); end
        tick();
        rob_flush = 1; #1;
        checks++; if (dc_if.bfs_dc_req !== 1'b0 || r0_grant !== 1'b0) begin errors++; $display("FAIL flush_r0_blocked got req=%b grant=%b required 0/0", dc_if.bfs_dc_req, r0_grant); end
        tick();
        rob_flush = 0; r0_req = 0; dc_if.dc_ready = 0; dc_if.dc_rbuf_empty = 0;
        for (int i = 0; i < 3; i++) begin
            dc_if.dc_fs = 1; dc_if.dc_rdata = 64'hA0 + 64'(i);
            if (i == 1) exp_q.push_back('{1'b1, 64'hA1});
            #1;
            checks++; if (r0_valid !== 1'b0) begin errors++; $display("FAIL flush_r0_squashed cyc %0d got %b required 0", i, r0_valid); end
            if (r1_valid === 1'b1) pulses++;
            tick();
        end
        dc_if.dc_fs = 0; #1;
        checks++; if (pulses != 1) begin errors++; $display("FAIL flush_r1_pulses got %0d required 1", pulses); end
        checks++; if (arb_idle !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got %b required 0", arb_idle); end
        dc_if.dc_rbuf_empty = 1; #1;
        checks++; if (arb_idle !== 1'b1) begin errors++; $display("FAIL flush_idle got %b required 1", arb_idle); end
`ifdef BFS_DCARB_STATS_EN
        checks++; if (stat_squash !== 32'd2) begin errors++; $display("FAIL stat_squash got %0d required 2", stat_squash); end
        checks++; if (stat_grant0 !== 32'd10 || stat_grant1 !== 32'd4) begin errors++; $display("FAIL stat_grants got %0d/%0d required 10/4", stat_grant0, stat_grant1); end
`endif
        // Flush coinciding with the response of a requester-0 head.
        r0_req = 1; r0_addr = 32'h0700; dc_if.dc_ready = 1;
        tick();
        r0_req = 0; dc_if.dc_ready = 0;
        rob_flush = 1; dc_if.dc_fs = 1; dc_if.dc_rdata = 64'hCC; #1;
        checks++; if (r0_valid !== 1'b0 || r0_rdata !== 64'd0) begin errors++; $display("FAIL flush_same_cycle got %b/%h required 0/0", r0_valid, r0_rdata); end
        tick();
        rob_flush = 0; dc_if.dc_fs = 0; #1;
        checks++; if (arb_idle !== 1'b1 || arb_err !== 1'b0) begin errors++; $display("FAIL flush_same_cycle_pop got idle=%b err=%b required 1/0", arb_idle, arb_err); end
`ifdef BFS_DCARB_STATS_EN
        checks++; if (stat_squash !== 32'd3) begin errors++; $display("FAIL stat_squash2 got %0d required 3", stat_squash); end
`endif
    endtask

    task automatic test_error_reset();
        dc_if.dc_fs = 1; dc_if.dc_rdata = 64'hBAD; #1;
        checks++; if (r0_valid !== 1'b0 || r1_valid !== 1'b0) begin errors++; $display("FAIL err_no_valid got %b%b required 00", r0_valid, r1_valid); end
        tick();
        dc_if.dc_fs = 0; #1;
        checks++; if (arb_err !== 1'b1) begin errors++; $display("FAIL err_set got %b required 1", arb_err); end
        tick(); tick();
        checks++; if (arb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b required 1", arb_err); end
        rst = 1;
        tick();
        rst = 0; #1;
        checks++; if (arb_err !== 1'b0 || dc_if.bfs_dc_req !== 1'b0) begin errors++; $display("FAIL err_reset got err=%b req=%b required 0/0", arb_err, dc_if.bfs_dc_req); end
        r0_req = 1; r1_req = 1; r0_addr = 32'h0800; r1_addr = 32'h0900; dc_if.dc_ready = 1; #1;
        checks++; if (r0_grant !== 1'b1 || r1_grant !== 1'b0 || dc_if.bfs_dc_addr !== 32'h0800) begin errors++; $display("FAIL err_tie_after_reset got r0=%b r1=%b addr=%h required 1/0/00000800", r0_grant, r1_grant, dc_if.bfs_dc_addr); end
        tick();
        r0_req = 0; r1_req = 0; dc_if.dc_ready = 0;
        dc_if.dc_fs = 1; dc_if.dc_rdata = 64'h77; exp_q.push_back('{1'b0, 64'h77});
        tick();
        dc_if.dc_fs = 0;
`ifdef BFS_DCARB_STATS_EN
        checks++; if (stat_grant0 !== 32'd1 || stat_grant1 !== 32'd0 || stat_squash !== 32'd0) begin errors++; $display("FAIL stat_after_reset got %0d/%0d/%0d required 1/0/0", stat_grant0, stat_grant1, stat_squash); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_tie();
        test_full();
        test_flush();
        test_error_reset();
        tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending responses required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
